// File: rtl/adder_seq_ctrl.sv
// Multi-word adder sequencer: adds NWORD words of BW_DATA bits on one narrow adder,
// LSW first, with the carry chained through a register between words.
module adder_seq_ctrl #(
  parameter int unsigned BW_DATA = 4,
  parameter int unsigned NWORD   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [BW_DATA*NWORD-1:0]   i_a,
  input  logic [BW_DATA*NWORD-1:0]   i_b,
  input  logic                       i_c,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [BW_DATA*NWORD-1:0]   o_s,
  output logic                       o_c,
  output logic                       o_busy
);

  localparam int unsigned W  = BW_DATA * NWORD;
  localparam int unsigned CW = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                carry;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        s_q;
  logic                c_q;
  logic                ready_q;
  logic                valid_q;
  logic                busy_q;

  logic [BW_DATA-1:0]  a_word_c;
  logic [BW_DATA-1:0]  b_word_c;
  logic [BW_DATA-1:0]  sum_c;
  logic                cy_c;

  // One-word slice of the adder, selected by the word counter
  always_comb begin
    a_word_c      = BW_DATA'(a_q >> (cnt * BW_DATA));
    b_word_c      = BW_DATA'(b_q >> (cnt * BW_DATA));
    {cy_c, sum_c} = {1'b0, a_word_c} + {1'b0, b_word_c} + (BW_DATA+1)'(carry);
  end

  // Sequencer: handshake flags are registered alongside the state
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_b;
            carry   <= i_c;
            cnt     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            state   <= CALC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          s_q[cnt*BW_DATA +: BW_DATA] <= sum_c;
          carry <= cy_c;
          if (cnt == LAST) begin
            c_q     <= cy_c;
            cnt     <= '0;
            state   <= DONE;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Result is held until the consumer takes it
          if (i_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_s     = s_q;
  assign o_c     = c_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a cycle model of the handshake and the wide sum,
// checked every cycle, plus directed operations with hand-computed results.
module tb_adder_seq_ctrl;

  localparam int unsigned BW = 4;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = BW * NW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid;
  logic          ready_out;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c;
  logic          valid_out;
  logic          rdy;
  logic [W-1:0]  s_out;
  logic          c_out;
  logic          busy_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.BW_DATA(BW), .NWORD(NW)) u_dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_valid (valid),
    .o_ready (ready_out),
    .i_a     (a),
    .i_b     (b),
    .i_c     (c),
    .o_valid (valid_out),
    .i_ready (rdy),
    .o_s     (s_out),
    .o_c     (c_out),
    .o_busy  (busy_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase -1 = idle, 0..NW-1 = words written so far, NW = result held
  int           m_phase   = -1;
  logic [W:0]   m_res     = '0;
  logic         m_fresh   = 1'b1;
  logic         m_started = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase   = -1;
      m_fresh   = 1'b1;
      m_started = 1'b1;
    end else if (m_phase == -1) begin
      if (valid) begin
        m_res   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        m_phase = 0;
        m_fresh = 1'b0;
      end
    end else if (m_phase < int'(NW)) begin
      m_phase = m_phase + 1;
    end else if (rdy) begin
      m_phase = -1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      logic [W-1:0] mask;
      check("ready", 32'(ready_out), 32'(m_phase == -1));
      check("busy",  32'(busy_out),  32'(m_phase != -1));
      check("valid", 32'(valid_out), 32'(m_phase == int'(NW)));
      if (m_phase == int'(NW))
        check("result", 32'({c_out, s_out}), 32'(m_res));
      if (m_phase >= 1 && m_phase < int'(NW)) begin
        mask = W'((1 << (m_phase * int'(BW))) - 1);
        check("partial", 32'(s_out & mask), 32'(m_res[W-1:0] & mask));
      end
      if (m_phase == -1 && m_fresh)
        check("reset_out", 32'({c_out, s_out}), 32'(0));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!ready_out && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) check("idle_timeout", 32'(ready_out), 32'(1));
  endtask

  // One operation: accept, measure latency, check literal result, optional backpressure
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                        input logic [W:0] exp, input int hold);
    int lat = 0;
    wait_idle();
    a = a_v; b = b_v; c = c_v; valid = 1'b1;
    rdy = (hold == 0);
    @(posedge clk); #1;
    valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    while (!valid_out && lat < 20) begin
      if (lat == 1) valid = 1'b1;
      if (lat == 2) valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(NW));
    check("sum_lit", 32'({c_out, s_out}), 32'(exp));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        valid = (i % 3 == 1);
        a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
      end
      valid = 1'b0;
      check("held_lit", 32'({c_out, s_out}), 32'(exp));
      rdy = 1'b1;
      @(posedge clk); #1;
      check("release_ready", 32'(ready_out), 32'(1));
    end else begin
      @(posedge clk); #1;
      check("one_cycle_valid", 32'(valid_out), 32'(0));
    end
    rdy = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   s;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'hABCD, 16'h1111, 1'b0, 17'h0BCDE},
    '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF},
    '{16'h0F0F, 16'hF0F1, 1'b0, 17'h10000},
    '{16'h7FFF, 16'h0001, 1'b0, 17'h08000},
    '{16'hDEAD, 16'hBEEF, 1'b1, 17'h19D9D},
    '{16'h0000, 16'h0000, 1'b0, 17'h00000},
    '{16'h1357, 16'h2468, 1'b1, 17'h037C0},
    '{16'h000F, 16'h0001, 1'b0, 17'h00010},
    '{16'h00F0, 16'h0010, 1'b0, 17'h00100},
    '{16'h0000, 16'hFFFF, 1'b1, 17'h10000}
  };

  initial begin
    rstn = 1'b0; valid = 1'b0; rdy = 1'b1; a = '0; b = '0; c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'(0));
    check("rst_busy",  32'(busy_out),  32'(0));
    check("rst_sum",   32'({c_out, s_out}), 32'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready_out), 32'(1));

    run_op(16'h1234, 16'h4321, 1'b0, 17'h05555, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 17'h10000, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 17'h05556, 10);

    // Reset while the third word is being computed
    wait_idle();
    a = 16'hFFFF; b = 16'h0001; c = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("midrst_valid", 32'(valid_out), 32'(0));
    check("midrst_sum",   32'({c_out, s_out}), 32'(0));
    check("midrst_ready", 32'(ready_out), 32'(1));
    run_op(16'h00FF, 16'h0001, 1'b0, 17'h00100, 0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, (i % 4 == 2) ? 3 : 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
